// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection phase controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    AG   = 3'd0,
    AY   = 3'd1,
    CLR  = 3'd2,
    BG   = 3'd3,
    BY   = 3'd4,
    WALK = 3'd5
  } state_t;

  typedef enum logic {
    STREET_A = 1'b0,
    STREET_B = 1'b1
  } street_t;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b11;

endpackage

// File: rtl/phase_timer.sv
// Up-counting phase timer: cleared on every phase change, holds at the saturate value.
module phase_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [CW-1:0] sat,
  output logic [CW-1:0] count
);

  // Count cycles spent in the current phase; saturation keeps long greens from wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_scheduler.sv
// Two-street intersection phase controller with a shared pedestrian crossing.
//
//   state | meaning
//   ------+----------------------------------------------
//   AG    | street A green, B red
//   AY    | street A yellow, B red
//   CLR   | all red for one cycle between phases
//   BG    | street B green, A red
//   BY    | street B yellow, A red
//   WALK  | all vehicle lamps red, walk lamp lit
module traffic_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int WALK_T    = 3,
  parameter int CW        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sa,
  input  logic       sb,
  input  logic       ped_req,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk
);

  localparam logic [CW-1:0] T_MIN  = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] T_MAX  = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] T_YEL  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] T_WALK = CW'(WALK_T - 1);

  state_t        state;
  state_t        state_nx;
  street_t       last;
  logic          ped_pending;
  logic [CW-1:0] timer;
  logic          phase_change;

  assign phase_change = (state_nx != state);

  phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (phase_change),
    .sat   (T_MAX),
    .count (timer)
  );

  // State register; reset lands directly in A green so lamps are valid without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= AG;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: a green yields only after its minimum, and before its maximum only if its own street is empty.
  always_comb begin
    state_nx = state;
    case (state)
      AG: begin
        if ((timer >= T_MIN) && (sb || ped_pending) && (!sa || (timer == T_MAX)))
          state_nx = AY;
      end
      AY: begin
        if (timer == T_YEL) state_nx = CLR;
      end
      BG: begin
        if ((timer >= T_MIN) && (sa || ped_pending) && (!sb || (timer == T_MAX)))
          state_nx = BY;
      end
      BY: begin
        if (timer == T_YEL) state_nx = CLR;
      end
      CLR: begin
        if (ped_pending)             state_nx = WALK;
        else if (last == STREET_A)   state_nx = BG;
        else                         state_nx = AG;
      end
      WALK: begin
        if (timer == T_WALK) state_nx = (last == STREET_A) ? BG : AG;
      end
      default: state_nx = AG;
    endcase
  end

  // Pedestrian latch and last-served street; entering WALK clears the latch even if a new request arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_pending <= 1'b0;
      last        <= STREET_A;
    end else begin
      if ((state_nx == WALK) && (state != WALK))
        ped_pending <= 1'b0;
      else if (ped_req && (state != WALK))
        ped_pending <= 1'b1;

      if ((state == AY) && (state_nx == CLR))
        last <= STREET_A;
      else if ((state == BY) && (state_nx == CLR))
        last <= STREET_B;
    end
  end

  // Moore lamp decode of the state register.
  always_comb begin
    la   = LAMP_RED;
    lb   = LAMP_RED;
    walk = 1'b0;
    case (state)
      AG:      la = LAMP_GRN;
      AY:      la = LAMP_YEL;
      BG:      lb = LAMP_GRN;
      BY:      lb = LAMP_YEL;
      WALK:    walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed, table-driven bench for traffic_scheduler with default parameters.
module tb_traffic_scheduler;
  import traffic_pkg::*;

  logic       clk;
  logic       reset;
  logic       sa;
  logic       sb;
  logic       ped_req;
  logic [1:0] la;
  logic [1:0] lb;
  logic       walk;

  traffic_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .sa      (sa),
    .sb      (sb),
    .ped_req (ped_req),
    .la      (la),
    .lb      (lb),
    .walk    (walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sa;
    logic       sb;
    logic       ped;
    logic [1:0] la;
    logic [1:0] lb;
    logic       walk;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input int n, input logic a, input logic b, input logic p,
                     input logic [1:0] ea, input logic [1:0] eb, input logic ew);
    vec_t v;
    v.sa = a; v.sb = b; v.ped = p; v.la = ea; v.lb = eb; v.walk = ew;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] ea,
                       input logic [1:0] eb, input logic ew);
    n_cmp++;
    if (la !== ea || lb !== eb || walk !== ew) begin
      n_bad++;
      $display("FAIL %s: got la=%b lb=%b walk=%b, expected la=%b lb=%b walk=%b",
               name, la, lb, walk, ea, eb, ew);
    end
  endtask

  // Hold reset across a clock edge, release it at a falling edge.
  task automatic do_reset();
    reset = 1'b0; sa = 1'b0; sb = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", LAMP_GRN, LAMP_RED, 1'b0);
    reset = 1'b1;
  endtask

  // Vector k holds the lamps expected during cycle k and the inputs driven during cycle k.
  task automatic run(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), vecs[i].la, vecs[i].lb, vecs[i].walk);
      sa = vecs[i].sa; sb = vecs[i].sb; ped_req = vecs[i].ped;
      @(negedge clk);
    end
    vecs.delete();
  endtask

  initial begin
    reset = 1'b0; sa = 1'b0; sb = 1'b0; ped_req = 1'b0;

    // Idle: A green holds forever.
    do_reset();
    add(30, 0, 0, 0, LAMP_GRN, LAMP_RED, 1'b0);
    run("idle");

    // B waiting, A empty: minimum green then hand over to B and hold.
    do_reset();
    add(4,  0, 1, 0, LAMP_GRN, LAMP_RED, 1'b0);
    add(2,  0, 1, 0, LAMP_YEL, LAMP_RED, 1'b0);
    add(1,  0, 1, 0, LAMP_RED, LAMP_RED, 1'b0);
    add(12, 0, 1, 0, LAMP_RED, LAMP_GRN, 1'b0);
    run("b_only");

    // Both streets busy: maximum green, alternating.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add(12, 1, 1, 0, LAMP_GRN, LAMP_RED, 1'b0);
      add(2,  1, 1, 0, LAMP_YEL, LAMP_RED, 1'b0);
      add(1,  1, 1, 0, LAMP_RED, LAMP_RED, 1'b0);
      add(12, 1, 1, 0, LAMP_RED, LAMP_GRN, 1'b0);
      add(2,  1, 1, 0, LAMP_RED, LAMP_YEL, 1'b0);
      add(1,  1, 1, 0, LAMP_RED, LAMP_RED, 1'b0);
    end
    add(3, 1, 1, 0, LAMP_GRN, LAMP_RED, 1'b0);
    run("contention");

    // Single pedestrian pulse, no vehicles: walk then B green since A was last.
    do_reset();
    add(1, 0, 0, 0, LAMP_GRN, LAMP_RED, 1'b0);
    add(1, 0, 0, 1, LAMP_GRN, LAMP_RED, 1'b0);
    add(2, 0, 0, 0, LAMP_GRN, LAMP_RED, 1'b0);
    add(2, 0, 0, 0, LAMP_YEL, LAMP_RED, 1'b0);
    add(1, 0, 0, 0, LAMP_RED, LAMP_RED, 1'b0);
    add(3, 0, 0, 0, LAMP_RED, LAMP_RED, 1'b1);
    add(8, 0, 0, 0, LAMP_RED, LAMP_GRN, 1'b0);
    run("ped_pulse");

    // Pedestrian with B waiting: walk before B green; request during walk is ignored.
    do_reset();
    add(1,  0, 1, 0, LAMP_GRN, LAMP_RED, 1'b0);
    add(1,  0, 1, 1, LAMP_GRN, LAMP_RED, 1'b0);
    add(2,  0, 1, 0, LAMP_GRN, LAMP_RED, 1'b0);
    add(2,  0, 1, 0, LAMP_YEL, LAMP_RED, 1'b0);
    add(1,  0, 1, 0, LAMP_RED, LAMP_RED, 1'b0);
    add(1,  0, 1, 0, LAMP_RED, LAMP_RED, 1'b1);
    add(1,  0, 1, 1, LAMP_RED, LAMP_RED, 1'b1);
    add(1,  0, 1, 0, LAMP_RED, LAMP_RED, 1'b1);
    add(14, 0, 1, 0, LAMP_RED, LAMP_GRN, 1'b0);
    run("ped_with_b");

    // Asynchronous reset in the middle of B yellow with a pedestrian latched.
    do_reset();
    add(4, 0, 1, 0, LAMP_GRN, LAMP_RED, 1'b0);
    add(2, 0, 1, 0, LAMP_YEL, LAMP_RED, 1'b0);
    add(1, 0, 1, 0, LAMP_RED, LAMP_RED, 1'b0);
    add(1, 1, 0, 1, LAMP_RED, LAMP_GRN, 1'b0);
    add(3, 1, 0, 0, LAMP_RED, LAMP_GRN, 1'b0);
    add(1, 1, 0, 0, LAMP_RED, LAMP_YEL, 1'b0);
    run("to_by");
    check("by_second_cycle", LAMP_RED, LAMP_YEL, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_immediate", LAMP_GRN, LAMP_RED, 1'b0);
    sa = 1'b0; sb = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    check("reset_held", LAMP_GRN, LAMP_RED, 1'b0);
    reset = 1'b1;
    add(20, 0, 0, 0, LAMP_GRN, LAMP_RED, 1'b0);
    run("after_reset_ped_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

- Cycle-accurate scheduler for a two-street intersection with a shared pedestrian crossing.
- Inputs: per-street vehicle sensors and a pedestrian request.
- Sequences green, yellow, all-red and walk phases, with minimum and maximum green times and alternating service.
- Drives the street-A/B lamp codes and the walk lamp directly; it sits above the lamp drivers as the intersection's single phase controller.

## Interface

Parameters:
- GREEN_MIN, 4: minimum green cycles before yielding.
- GREEN_MAX, 12: maximum green cycles while the other side or the pedestrian is waiting.
- YELLOW_T, 2: yellow cycles.
- WALK_T, 3: walk cycles.
- CW, 5: phase timer width; GREEN_MAX < 2**CW required.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sa  in  1  street-A vehicle present (level).
- sb  in  1  street-B vehicle present (level).
- ped_req  in  1  pedestrian request; single-cycle pulse or level.
- la  out  2  street-A lamp: 2'b11 green, 2'b01 yellow, 2'b00 red.
- lb  out  2  street-B lamp, same encoding.
- walk  out  1  pedestrian walk lamp.

## Operation

- States: AG, AY, CLR, BG, BY, WALK.
  - Outputs are a Moore decode of the state register.
  - AG: la=11, lb=00. AY: la=01, lb=00. BG: lb=11, la=00. BY: lb=01, la=00.
  - CLR: la=lb=00. WALK: la=lb=00, walk=1.
  - walk=0 in every state except WALK.
- Reset (reset=0): state=AG, timer=0, last=A, ped_pending=0, outputs la=11, lb=00, walk=0.
- Phase timer: cleared on every state change, +1 per cycle otherwise, saturates at GREEN_MAX-1.
- ped_pending:
  - Set on ped_req=1 in any state except WALK.
  - Cleared on the edge entering WALK; the clear wins over a simultaneous set.
- AG → AY when timer ≥ GREEN_MIN-1 and (sb | ped_pending) and (!sa | timer == GREEN_MAX-1). Otherwise hold.
- With no request, green holds indefinitely.
- BG → BY: symmetric, with sa and sb swapped.
- AY/BY → CLR when timer == YELLOW_T-1. The `last` register records the street that was just served.
- CLR, 1 cycle:
  - → WALK if ped_pending.
  - Else → green of the street ≠ last.
- WALK → green of the street ≠ last when timer == WALK_T-1.
- Every phase change from green passes through yellow and CLR. There is never a direct green → green or walk-during-green.

## Timing

- Sensors and ped_req are sampled on the rising clk edge. The state change and new lamp values appear on that same edge.
- Minimum phase lengths:
  - Green: GREEN_MIN cycles.
  - Yellow: YELLOW_T cycles.
  - CLR: 1 cycle.
  - Walk: WALK_T cycles.
- Maximum green under contention is GREEN_MAX cycles.
- Defaults, from AG entry with sb=1 and sa=0:
  - la=11 for cycles 0–3.
  - la=01 for cycles 4–5.
  - All red at cycle 6.
  - lb=11 from cycle 7.
- Reset assertion mid-phase forces the reset values immediately, without waiting for clk. The first AG after reset release starts with timer=0.
- Simultaneous sb and ped_pending at CLR: WALK is served first, then BG.

## Structure

- Package traffic_pkg:
  - state enum (AG, AY, CLR, BG, BY, WALK).
  - lamp codes LAMP_RED=2'b00, LAMP_YEL=2'b01, LAMP_GRN=2'b11.
  - street enum (STREET_A, STREET_B) used for last.
- Sub-module phase_timer, parameterised on CW:
  - Inputs: clr, and a saturate value.
  - Output: count.
  - Async active-low reset.
- Top: state register, next-state logic, ped_pending and last flops, output decode.

## Test plan

- Reset, then sa=sb=ped_req=0 for 30 cycles → la=11, lb=00, walk=0 throughout.
- sb=1, sa=0 held after reset → la 11×4, 01×2, 00 with lb=00 ×1, then lb=11 held while sa=0.
- sa=sb=1 held → A green exactly 12 cycles, yellow 2, CLR 1; B green 12; the pattern repeats, alternating.
- One-cycle ped_req at cycle 1, sa=sb=0:
  - la 11×4, 01×2, CLR ×1.
  - Then walk=1 with la=lb=00 ×3.
  - Then lb=11, because last=A.
- ped_req pulse during WALK → no second WALK; ped_req together with sb=1 during AG → WALK precedes BG.
- reset=0 asserted mid-BY between clock edges → la=11, lb=00, walk=0 immediately; ped_pending cleared.
